aurora_traffic_gen_chk: RTL

Link-level traffic generator and checker for one aurora_dual channel (SMA or SFP side).
- TX half drives the channel's user-side D/D_VALID input with a deterministic counting burst and honours D_BP.
- RX half consumes Q/Q_VALID, drives Q_BP, and compares every received word against the expected sequence.
- Reports transfer counts, mismatch count and pass/fail. Used for on-board and simulation loopback qualification once CH_UP rises.

---
 rtl/aurora_traffic_gen_chk.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/aurora_traffic_gen_chk.sv
// aurora_traffic_gen_chk
//   Link-level traffic generator and checker for one aurora_dual channel.
//   TX half emits a counting burst on D/D_VALID and honours D_BP; RX half
//   checks every Q/Q_VALID word against the same counting sequence and
//   reports transfer counts, error count and pass/fail.
//
//   Word k carries (SEED + k) mod 2^32 in every 32-bit lane of the W-bit bus.
//
// Ports
//   CLK, RST          clock, synchronous active-high reset
//   CH_UP             channel-up from aurora_dual
//   START             single-cycle pulse, begins a run (ignored while busy)
//   RX_HOLD           test control, registered onto Q_BP
//   D, D_VALID, D_BP  TX user interface toward aurora_dual
//   Q, Q_VALID, Q_BP  RX user interface from aurora_dual
//   TX_CNT, RX_CNT    words transferred / received this run
//   ERR_CNT           mismatching or surplus words, saturating
//   BUSY, DONE, PASS  run status; PASS meaningful only while DONE=1
//   TIMEOUT_ERR       run aborted because RX made no progress
//   LINK_ERR          run aborted because CH_UP dropped
module aurora_traffic_gen_chk #(
  parameter int          W         = 64,
  parameter logic [31:0] SEED      = 32'h0000_0000,
  parameter int          BURST_LEN = 256,
  parameter int          TIMEOUT   = 65535
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CH_UP,
  input  logic         START,
  input  logic         RX_HOLD,
  output logic [W-1:0] D,
  output logic         D_VALID,
  input  logic         D_BP,
  input  logic [W-1:0] Q,
  input  logic         Q_VALID,
  output logic         Q_BP,
  output logic [15:0]  TX_CNT,
  output logic [15:0]  RX_CNT,
  output logic [15:0]  ERR_CNT,
  output logic         BUSY,
  output logic         DONE,
  output logic         PASS,
  output logic         TIMEOUT_ERR,
  output logic         LINK_ERR
);

  localparam int          LANES = W / 32;
  // Counters carry one extra bit so BURST_LEN = 2^16 compares exactly.
  localparam logic [16:0] BL    = 17'(BURST_LEN);
  localparam logic [31:0] TMO   = 32'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_UP, S_RUN, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [16:0] tx_cnt, rx_cnt, tx_cnt_nxt, rx_cnt_nxt;
  logic [15:0] err_cnt, err_cnt_nxt;
  logic [31:0] tmo_cnt, tmo_cnt_nxt;
  logic        tmo_err_nxt, link_err_nxt;
  logic        clear, tmo_hit, link_hit;
  logic        tx_fire, rx_fire, rx_bad;

  function automatic logic [W-1:0] pattern(input logic [16:0] k);
    logic [31:0] v;
    v = SEED + {15'd0, k};
    return {LANES{v}};
  endfunction

  assign tx_fire = (state == S_RUN) && D_VALID && !D_BP;
  // Every Q_VALID word in RUN is taken; Q_BP is advisory only.
  assign rx_fire = (state == S_RUN) && Q_VALID;
  // Expected value is indexed by the receive count, so it advances on
  // every accepted word even when that word is corrupt.
  assign rx_bad  = rx_fire && ((rx_cnt >= BL) || (Q != pattern(rx_cnt)));

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    tmo_hit   = 1'b0;
    link_hit  = 1'b0;
    case (state)
      S_IDLE: if (START) begin
        state_nxt = S_WAIT_UP;
        clear     = 1'b1;
      end
      S_WAIT_UP: begin
        if (CH_UP) state_nxt = S_RUN;
        else if (tmo_cnt >= TMO) begin
          state_nxt = S_DONE;
          tmo_hit   = 1'b1;
        end
      end
      S_RUN: begin
        if (!CH_UP) begin
          state_nxt = S_DONE;
          link_hit  = 1'b1;
        end else if (tx_cnt == BL && rx_cnt == BL) begin
          state_nxt = S_DONE;
        end else if (tmo_cnt >= TMO) begin
          state_nxt = S_DONE;
          tmo_hit   = 1'b1;
        end
      end
      S_DONE: if (START) begin
        state_nxt = S_WAIT_UP;
        clear     = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase

    tx_cnt_nxt   = clear ? '0 : tx_cnt + 17'(tx_fire);
    rx_cnt_nxt   = clear ? '0 : rx_cnt + 17'(rx_fire);
    err_cnt_nxt  = err_cnt;
    if (clear) err_cnt_nxt = '0;
    else if (rx_bad && err_cnt != 16'hFFFF) err_cnt_nxt = err_cnt + 16'd1;
    tmo_err_nxt  = !clear && (TIMEOUT_ERR || tmo_hit);
    link_err_nxt = !clear && (LINK_ERR || link_hit);

    // Idle timer: zero on WAIT_UP entry and on RX progress.
    tmo_cnt_nxt = tmo_cnt;
    if (clear) tmo_cnt_nxt = '0;
    else if (state == S_WAIT_UP || state == S_RUN)
      tmo_cnt_nxt = rx_fire ? '0 : tmo_cnt + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      tx_cnt      <= '0;
      rx_cnt      <= '0;
      err_cnt     <= '0;
      tmo_cnt     <= '0;
      D           <= '0;
      D_VALID     <= 1'b0;
      Q_BP        <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      PASS        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      LINK_ERR    <= 1'b0;
    end else begin
      state       <= state_nxt;
      tx_cnt      <= tx_cnt_nxt;
      rx_cnt      <= rx_cnt_nxt;
      err_cnt     <= err_cnt_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      TIMEOUT_ERR <= tmo_err_nxt;
      LINK_ERR    <= link_err_nxt;
      Q_BP        <= RX_HOLD;
      // Outputs are computed from next-state values so they line up with
      // the state they describe; D only moves after an accepted transfer.
      D_VALID     <= (state_nxt == S_RUN) && (tx_cnt_nxt < BL);
      if (state_nxt == S_RUN) D <= pattern(tx_cnt_nxt);
      BUSY        <= (state_nxt == S_WAIT_UP) || (state_nxt == S_RUN);
      DONE        <= (state_nxt == S_DONE);
      PASS        <= (state_nxt == S_DONE) && (err_cnt_nxt == 16'd0) &&
                     !tmo_err_nxt && !link_err_nxt;
    end
  end

  assign TX_CNT  = tx_cnt[15:0];
  assign RX_CNT  = rx_cnt[15:0];
  assign ERR_CNT = err_cnt;

endmodule
